// File: rtl/stack_ctrl.sv
// Stack controller: TOS held in a register, lower entries spilled to / filled from an external RAM.
// Optional overflow/underflow protection via the STACK_CTRL_CHECK_EN macro (default: circular CPU-style stack).
module stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DEPTH+1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic [DEPTH-1:0] mem_ra,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_wa,
  output logic [WIDTH-1:0] mem_wd
);

  localparam int CW = DEPTH + 2;
  localparam logic [CW-1:0]    CAP       = CW'((1 << DEPTH) + 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [DEPTH-1:0] SP_ONE    = DEPTH'(1);
  localparam logic [DEPTH-1:0] SP_RESET  = '1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,     // push into an empty stack: TOS only, nothing to spill
    OP_PUSH,     // spill old TOS to RAM, load din
    OP_POP,      // fill TOS from RAM
    OP_DRAIN,    // pop the last entry
    OP_REPLACE,  // push&pop on a non-empty stack
    OP_OVF,
    OP_UNF
  } op_t;

  op_t op;

  logic [WIDTH-1:0] tos_reg, tos_next;
  logic [DEPTH-1:0] sp_reg, sp_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             we;
  logic             is_empty, is_full;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CAP);

  // Operation decode: push&pop on an empty stack degenerates to a plain push.
  always_comb begin
    op = OP_HOLD;
    if (push && (!pop || is_empty)) begin
      if (is_empty) begin
        op = OP_LOAD;
      end else if (!is_full) begin
        op = OP_PUSH;
      end else begin
`ifdef STACK_CTRL_CHECK_EN
        op = OP_OVF;
`else
        op = OP_PUSH;
`endif
      end
    end else if (push && pop) begin
      op = OP_REPLACE;
    end else if (pop) begin
      if (count_reg > CNT_ONE) begin
        op = OP_POP;
      end else if (count_reg == CNT_ONE) begin
        op = OP_DRAIN;
      end else begin
`ifdef STACK_CTRL_CHECK_EN
        op = OP_UNF;
`else
        op = OP_POP;
`endif
      end
    end
  end

  always_comb begin
    tos_next   = tos_reg;
    sp_next    = sp_reg;
    count_next = count_reg;
    we         = 1'b0;
    unique case (op)
      OP_LOAD: begin
        tos_next   = din;
        count_next = CNT_ONE;
      end
      OP_PUSH: begin
        we       = 1'b1;
        sp_next  = sp_reg + SP_ONE;
        tos_next = din;
        // When full (circular mode) the oldest RAM entry is overwritten and count saturates.
        if (!is_full) count_next = count_reg + CNT_ONE;
      end
      OP_POP: begin
        tos_next = mem_rd;
        sp_next  = sp_reg - SP_ONE;
        if (!is_empty) count_next = count_reg - CNT_ONE;
      end
      OP_DRAIN: begin
        tos_next   = '0;
        count_next = '0;
      end
      OP_REPLACE: begin
        tos_next = din;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tos_reg   <= '0;
      sp_reg    <= SP_RESET;
      count_reg <= '0;
    end else begin
      tos_reg   <= tos_next;
      sp_reg    <= sp_next;
      count_reg <= count_next;
    end
  end

`ifdef STACK_CTRL_CHECK_EN
  logic ovf_reg, unf_reg;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (op == OP_OVF) ovf_reg <= 1'b1;
      if (op == OP_UNF) unf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
  assign unf = unf_reg;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign tos    = tos_reg;
  assign nos    = mem_rd;
  assign count  = count_reg;
  assign empty  = is_empty;
  assign full   = is_full;
  assign mem_ra = sp_reg;
  assign mem_wa = sp_reg + SP_ONE;
  assign mem_wd = tos_reg;
  assign mem_we = we;

endmodule
